// File: rtl/axil_led_ctrl.sv
// AXI4-Lite LED controller: direct/atomic LED writes, per-LED blink, ID register.
// One outstanding read and one outstanding write; undecoded or unaligned accesses return SLVERR.
module axil_led_ctrl #(
  parameter int unsigned                NUM_LEDS       = 4,
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BASE_ADDR      = 32'h43C00000,
  parameter logic [31:0]                BLINK_DIV_RST  = 32'd50_000_000
) (
  input  logic                      sys_clk,
  input  logic                      sys_reset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [NUM_LEDS-1:0]       led_pins
);

  typedef enum logic [2:0] {
    SEL_OUT, SEL_SET, SEL_CLR, SEL_TGL, SEL_BEN, SEL_DIV, SEL_ID, SEL_NONE
  } sel_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VAL      = {16'h4C45, 8'h02, 8'(NUM_LEDS)};

  function automatic sel_t decode(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] off;
    sel_t sel;
    off = addr - BASE_ADDR;
    sel = SEL_NONE;
    if (addr >= BASE_ADDR && off < AXI_ADDR_WIDTH'(32) && addr[1:0] == 2'b00) begin
      case (off[4:2])
        3'd0:    sel = SEL_OUT;
        3'd1:    sel = SEL_SET;
        3'd2:    sel = SEL_CLR;
        3'd3:    sel = SEL_TGL;
        3'd4:    sel = SEL_BEN;
        3'd5:    sel = SEL_DIV;
        3'd6:    sel = SEL_ID;
        default: sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

  logic                      aw_held, w_held;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]               w_data_q;
  logic [3:0]                w_strb_q;

  logic [NUM_LEDS-1:0] led_out, led_out_nxt;
  logic [NUM_LEDS-1:0] blink_en, blink_en_nxt;
  logic [31:0]         blink_div, blink_div_nxt;
  logic [31:0]         blink_cnt;
  logic                blink_phase;

  logic                      aw_hs, w_hs, ar_hs, do_write, div_wr;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]               wr_data, byte_mask, wr_bits, rd_val;
  logic [3:0]                wr_strb;
  logic [1:0]                wr_resp, rd_resp;
  logic [NUM_LEDS-1:0]       mask_n, bits_n;
  sel_t                      wr_sel, rd_sel;

  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // A held beat and a live handshake on the other channel complete in the same cycle.
  always_comb begin
    wr_addr   = aw_held ? aw_addr_q : s_axi_awaddr;
    wr_data   = w_held ? w_data_q : s_axi_wdata;
    wr_strb   = w_held ? w_strb_q : s_axi_wstrb;
    do_write  = (aw_held || aw_hs) && (w_held || w_hs) && !s_axi_bvalid;
    wr_sel    = decode(wr_addr);
    byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    wr_bits   = wr_data & byte_mask;
    mask_n    = byte_mask[NUM_LEDS-1:0];
    bits_n    = wr_bits[NUM_LEDS-1:0];
    wr_resp   = (wr_sel == SEL_NONE || wr_sel == SEL_ID) ? RESP_SLVERR : RESP_OKAY;
  end

  always_comb begin
    led_out_nxt   = led_out;
    blink_en_nxt  = blink_en;
    blink_div_nxt = blink_div;
    div_wr        = 1'b0;
    if (do_write) begin
      case (wr_sel)
        SEL_OUT: led_out_nxt  = (led_out & ~mask_n) | bits_n;
        SEL_SET: led_out_nxt  = led_out | bits_n;
        SEL_CLR: led_out_nxt  = led_out & ~bits_n;
        SEL_TGL: led_out_nxt  = led_out ^ bits_n;
        SEL_BEN: blink_en_nxt = (blink_en & ~mask_n) | bits_n;
        SEL_DIV: begin
          blink_div_nxt = (blink_div & ~byte_mask) | wr_bits;
          div_wr        = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_sel = decode(s_axi_araddr);
    case (rd_sel)
      SEL_OUT: rd_val = 32'(led_out);
      SEL_BEN: rd_val = 32'(blink_en);
      SEL_DIV: rd_val = blink_div;
      SEL_ID:  rd_val = ID_VAL;
      default: rd_val = '0;
    endcase
    rd_resp = (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
      led_out      <= '0;
      blink_en     <= '0;
      blink_div    <= BLINK_DIV_RST;
      blink_cnt    <= '0;
      blink_phase  <= 1'b1;
      led_pins     <= '0;
    end else begin
      if (do_write) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end else begin
        if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
      end

      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_val;
        s_axi_rresp  <= rd_resp;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end

      led_out   <= led_out_nxt;
      blink_en  <= blink_en_nxt;
      blink_div <= blink_div_nxt;

      if (div_wr || blink_div == '0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt >= blink_div) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 32'd1;
      end

      led_pins <= led_out & (~blink_en | {NUM_LEDS{blink_phase}});
    end
  end

endmodule
